// File: rtl/cla_pkg.sv
// Shared types and configuration helpers for the pipelined carry-lookahead adder.
// The stage record is sized for the widest supported operand; each instance uses the low WIDTH bits.
package cla_pkg;

    localparam int CLA_MAX_W = 64;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic                 valid;
        op_e                  op;
        logic [CLA_MAX_W-1:0] a_rem;
        logic [CLA_MAX_W-1:0] b_rem;
        logic [CLA_MAX_W-1:0] sum_done;
        logic                 carry;
    } stage_t;

    function automatic int cla_nstg(input int width, input int seg);
        return width / seg;
    endfunction

    function automatic bit cla_cfg_ok(input int width, input int seg);
        return (seg >= 2) && (seg <= 8) && (width >= seg) &&
               ((width % seg) == 0) && (width <= CLA_MAX_W);
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_group.sv
// Combinational SEG-bit carry-lookahead group.
// Every carry is a flat sum of generate/propagate products, so nothing ripples inside the group.
module cla_group
    import cla_pkg::*;
#(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb_in
);

    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic term;
        logic acc;
        term = 1'b0;
        acc  = 1'b0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            acc = 1'b0;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                acc = acc | term;
            end
            term = ci;
            for (int k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            c[i+1] = acc | term;
        end
    end

    assign s        = p ^ c[SEG-1:0];
    assign co       = c[SEG];
    assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, one SEG-bit group per stage, valid/ready on both sides.
// Operands are registered on accept; stage k adds segment k and hands its carry to stage k+1.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTG = cla_nstg(WIDTH, SEG);

    if (!cla_cfg_ok(WIDTH, SEG)) begin : g_cfg_err
        $error("pipelined_cla_adder: WIDTH must be a multiple of SEG with SEG in 2..8");
    end

    stage_t stg_q [NSTG];
    stage_t stg_d [NSTG];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [SEG-1:0] grp_s  [NSTG];
    logic           grp_co [NSTG];
    logic           grp_cm [NSTG];

    logic advance;
    logic accept;

    assign advance  = out_ready || !out_valid_q;
    assign accept   = in_valid && advance;
    assign in_ready = advance;

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        cla_group #(.SEG(SEG)) u_grp (
            .a        (stg_q[k].a_rem[k*SEG +: SEG]),
            .b        (stg_q[k].b_rem[k*SEG +: SEG]),
            .ci       (stg_q[k].carry),
            .s        (grp_s[k]),
            .co       (grp_co[k]),
            .c_msb_in (grp_cm[k])
        );
    end

    always_comb begin
        logic [CLA_MAX_W-1:0] last_sum;
        stg_d       = stg_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        last_sum    = stg_q[NSTG-1].sum_done;
        last_sum[(NSTG-1)*SEG +: SEG] = grp_s[NSTG-1];

        if (advance) begin
            // Bubbles carry all-zero data so an idle pipeline settles to a zero result.
            stg_d[0] = '0;
            if (accept) begin
                stg_d[0].valid            = 1'b1;
                stg_d[0].op               = op_e'(op);
                stg_d[0].a_rem[WIDTH-1:0] = a;
                stg_d[0].b_rem[WIDTH-1:0] = op ? ~b : b;
                stg_d[0].carry            = op ? 1'b1 : cin;
            end
            for (int k = 1; k < NSTG; k++) begin
                stg_d[k] = stg_q[k-1];
                stg_d[k].sum_done[(k-1)*SEG +: SEG] = grp_s[k-1];
                stg_d[k].carry = grp_co[k-1];
            end
            out_valid_d = stg_q[NSTG-1].valid;
            sum_d       = last_sum[WIDTH-1:0];
            cout_d      = grp_co[NSTG-1];
            ovf_d       = grp_co[NSTG-1] ^ grp_cm[NSTG-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTG; k++) begin
                stg_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                stg_q[k] <= stg_d[k];
            end
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed, table-driven bench for pipelined_cla_adder at the default 16-bit / 4-bit-group configuration.
module tb_pipelined_cla_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    pipelined_cla_adder #(.WIDTH(16), .SEG(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vcin;
        logic        vop;
        logic [15:0] esum;
        logic        ecout;
        logic        eovf;
    } vec_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned n_rx  = 0;
    logic [17:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Independent reference: plain wide addition, carry into the MSB recovered from the sum bit.
    function automatic logic [17:0] ref_calc(input logic [15:0] ra, input logic [15:0] rb,
                                             input logic rcin, input logic rop);
        logic [15:0] bb;
        logic [16:0] full;
        logic        c15;
        bb   = rop ? ~rb : rb;
        full = {1'b0, ra} + {1'b0, bb} + {16'd0, (rop ? 1'b1 : rcin)};
        c15  = ra[15] ^ bb[15] ^ full[15];
        return {c15 ^ full[16], full[16], full[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock of streaming traffic with scoreboard checking of every visible result.
    task automatic drive_cycle(input logic v, input logic [15:0] ta, input logic [15:0] tb_,
                               input logic tcin, input logic top, input logic ordy,
                               output logic acc);
        logic fire;
        logic [17:0] front;
        out_ready = ordy;
        in_valid  = v;
        a         = ta;
        b         = tb_;
        cin       = tcin;
        op        = top;
        #1;
        acc  = v && in_ready;
        fire = out_valid && out_ready;
        if (acc) exp_q.push_back(ref_calc(ta, tb_, tcin, top));
        @(posedge clk);
        #1;
        if (fire && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            n_rx++;
        end
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                front = exp_q[0];
                chk("stream_result", {14'd0, ovf, cout, sum}, {14'd0, front});
            end
        end
    endtask

    task automatic apply_vec(input vec_t tv, input string tag);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = tv.va;
        b         = tv.vb;
        cin       = tv.vcin;
        op        = tv.vop;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 12) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_sum"}, {16'd0, sum}, {16'd0, tv.esum});
        chk({tag, "_cout"}, 32'(cout), 32'(tv.ecout));
        chk({tag, "_ovf"}, 32'(ovf), 32'(tv.eovf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [11];
        vec_t rv;
        logic acc;
        logic [15:0] sa [6];
        logic [15:0] sb [6];
        logic        sop [6];
        logic [15:0] held_sum;
        int idx;
        int cyc;
        int rx0;

        vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[9]  = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[10] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; op = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_sum", {16'd0, sum}, 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);

        for (int i = 0; i < 11; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end
        step();

        // Back-to-back stream: eight random beats, one result per cycle in order.
        rx0 = n_rx;
        for (int i = 0; i < 13; i++) begin
            if (i < 8) begin
                drive_cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, acc);
                chk("stream_in_ready", 32'(acc), 32'd1);
            end else begin
                drive_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
            end
            if (i == 11) chk("stream_rx_after_12", n_rx - rx0, 32'd7);
        end
        chk("stream_rx_total", n_rx - rx0, 32'd8);
        chk("stream_queue_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: six beats, out_ready low from the third cycle until cycle 10.
        for (int i = 0; i < 6; i++) begin
            sa[i]  = 16'h1111 * 16'(i + 1);
            sb[i]  = 16'h0F0F + 16'(i * 3);
            sop[i] = 1'(i % 2);
        end
        rx0 = n_rx;
        idx = 0;
        held_sum = '0;
        for (cyc = 0; cyc < 40 && (idx < 6 || exp_q.size() > 0); cyc++) begin
            if (idx < 6)
                drive_cycle(1'b1, sa[idx], sb[idx], 1'b0, sop[idx], (cyc < 2) || (cyc >= 10), acc);
            else
                drive_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
            if (acc) idx++;
            if (cyc == 6) held_sum = sum;
            if (cyc == 9) begin
                chk("full_in_ready_low", 32'(in_ready), 32'd0);
                chk("full_accepted", 32'(idx), 32'd5);
                chk("full_out_valid", 32'(out_valid), 32'd1);
                chk("full_sum_held", {16'd0, sum}, {16'd0, held_sum});
            end
        end
        chk("bp_all_accepted", 32'(idx), 32'd6);
        chk("bp_rx_total", n_rx - rx0, 32'd6);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with beats in flight and a result waiting at the output.
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 16'h1111 + 16'(i), 16'h2222, 1'b0, 1'b0, 1'b0, acc);
        end
        chk("prereset_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_sum", {16'd0, sum}, 32'd0);
        chk("async_rst_cout", 32'(cout), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        rv = '{16'h0123, 16'h0456, 1'b0, 1'b0, 16'h0579, 1'b0, 1'b0};
        apply_vec(rv, "post_reset");
        repeat (6) begin
            step();
            chk("post_reset_no_stale", 32'(out_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
